// File: rtl/sa_phase_scheduler.sv
// Training-pass sequencer for the systolic array: walks FP, BP and WG over every layer/tile and
// drives the PE feed/clear, output-buffer strobes/selects and the input-prefetch mode.
module sa_phase_scheduler #(
    parameter int TILE_CYC  = 8,
    parameter int DRAIN_CYC = 4,
    parameter int RST_CYC   = 1,
    parameter int LAYER_W   = 4,
    parameter int TILE_W    = 6
) (
    input  logic                    clk,
    input  logic                    fsm_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LAYER_W-1:0]      cfg_layers,
    input  logic [TILE_W-1:0]       cfg_tiles,
    input  logic [2**LAYER_W-1:0]   cfg_stride_mask,
    input  logic                    buf_ready,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              phase,
    output logic [LAYER_W-1:0]      layer_idx,
    output logic [TILE_W-1:0]       tile_idx,
    output logic                    in_en,
    output logic                    pe_clr,
    output logic                    drain_en,
    output logic                    stride,
    output logic [1:0]              inpref_mode,
    output logic                    buf_input_select,
    output logic                    buf_output_select
);

    localparam int CNT_W  = 8;
    localparam int MASK_W = 2**LAYER_W;
    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_FP   = 2'b01;
    localparam logic [1:0] PH_BP   = 2'b10;
    localparam logic [1:0] PH_WG   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_CLEAR = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [1:0]           phase_r, phase_s;
    logic [LAYER_W-1:0]   layer_r, layer_s;
    logic [TILE_W-1:0]    tile_r, tile_s;
    logic                 stride_r, stride_s;
    logic [1:0]           inpref_r, inpref_s;
    logic [LAYER_W-1:0]   cfg_layers_r, cfg_layers_s;
    logic [TILE_W-1:0]    cfg_tiles_r, cfg_tiles_s;
    logic [MASK_W-1:0]    mask_r, mask_s;
    logic                 finish_s;

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state_r      <= S_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            phase_r      <= PH_IDLE;
            layer_r      <= {LAYER_W{1'b0}};
            tile_r       <= {TILE_W{1'b0}};
            stride_r     <= 1'b0;
            inpref_r     <= 2'b00;
            cfg_layers_r <= {LAYER_W{1'b0}};
            cfg_tiles_r  <= {TILE_W{1'b0}};
            mask_r       <= {MASK_W{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            phase_r      <= phase_s;
            layer_r      <= layer_s;
            tile_r       <= tile_s;
            stride_r     <= stride_s;
            inpref_r     <= inpref_s;
            cfg_layers_r <= cfg_layers_s;
            cfg_tiles_r  <= cfg_tiles_s;
            mask_r       <= mask_s;
        end
    end

    // Next-state logic: phase/tile sequencing; indices, stride and prefetch mode move together in NEXT.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        phase_s      = phase_r;
        layer_s      = layer_r;
        tile_s       = tile_r;
        stride_s     = stride_r;
        inpref_s     = inpref_r;
        cfg_layers_s = cfg_layers_r;
        cfg_tiles_s  = cfg_tiles_r;
        mask_s       = mask_r;
        finish_s     = 1'b0;
        if (abort) begin
            state_s  = S_IDLE;
            cnt_s    = {CNT_W{1'b0}};
            phase_s  = PH_IDLE;
            layer_s  = {LAYER_W{1'b0}};
            tile_s   = {TILE_W{1'b0}};
            stride_s = 1'b0;
            inpref_s = 2'b00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cfg_layers_s = cfg_layers;
                        cfg_tiles_s  = cfg_tiles;
                        mask_s       = cfg_stride_mask;
                        if ((cfg_layers == {LAYER_W{1'b0}}) || (cfg_tiles == {TILE_W{1'b0}})) begin
                            state_s = S_DONE;
                        end else begin
                            state_s  = S_LOAD;
                            phase_s  = PH_FP;
                            stride_s = cfg_stride_mask[0];
                            inpref_s = {1'b0, ~cfg_stride_mask[0]};
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_s = S_FEED;
                    cnt_s   = {CNT_W{1'b0}};
                end
                S_FEED: begin
                    if (cnt_r == CNT_W'(TILE_CYC - 1)) begin
                        state_s = S_DRAIN;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (buf_ready && (cnt_r == CNT_W'(DRAIN_CYC - 1))) begin
                        state_s = S_CLEAR;
                        cnt_s   = {CNT_W{1'b0}};
                    end else if (buf_ready) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                S_CLEAR: begin
                    if (cnt_r == CNT_W'(RST_CYC - 1)) begin
                        state_s = S_NEXT;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    state_s = S_FEED;
                    if (tile_r != (cfg_tiles_r - TILE_W'(1))) begin
                        tile_s = tile_r + TILE_W'(1);
                    end else begin
                        tile_s = {TILE_W{1'b0}};
                        case (phase_r)
                            PH_FP: begin
                                if (layer_r == (cfg_layers_r - LAYER_W'(1))) begin
                                    phase_s = PH_BP;
                                end else begin
                                    layer_s = layer_r + LAYER_W'(1);
                                end
                            end
                            PH_BP: begin
                                if (layer_r == {LAYER_W{1'b0}}) begin
                                    phase_s = PH_WG;
                                    layer_s = cfg_layers_r - LAYER_W'(1);
                                end else begin
                                    layer_s = layer_r - LAYER_W'(1);
                                end
                            end
                            PH_WG: begin
                                if (layer_r == {LAYER_W{1'b0}}) begin
                                    finish_s = 1'b1;
                                end else begin
                                    layer_s = layer_r - LAYER_W'(1);
                                end
                            end
                            default: finish_s = 1'b1;
                        endcase
                    end
                    if (finish_s) begin
                        state_s  = S_DONE;
                        phase_s  = PH_IDLE;
                        layer_s  = {LAYER_W{1'b0}};
                        tile_s   = {TILE_W{1'b0}};
                        stride_s = 1'b0;
                        inpref_s = 2'b00;
                    end else begin
                        stride_s = mask_r[layer_s];
                        inpref_s = {(tile_s != {TILE_W{1'b0}}), ~mask_r[layer_s]};
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s  = S_IDLE;
                    cnt_s    = {CNT_W{1'b0}};
                    phase_s  = PH_IDLE;
                    layer_s  = {LAYER_W{1'b0}};
                    tile_s   = {TILE_W{1'b0}};
                    stride_s = 1'b0;
                    inpref_s = 2'b00;
                end
            endcase
        end
    end

    // Moore output decode straight from the state/index registers (drain strobe qualified by buf_ready).
    always_comb begin
        busy              = (state_r != S_IDLE);
        done              = (state_r == S_DONE);
        in_en             = (state_r == S_FEED);
        pe_clr            = (state_r == S_CLEAR);
        drain_en          = (state_r == S_DRAIN) && buf_ready;
        phase             = phase_r;
        layer_idx         = layer_r;
        tile_idx          = tile_r;
        stride            = stride_r;
        inpref_mode       = inpref_r;
        buf_input_select  = (phase_r == PH_FP);
        buf_output_select = (phase_r == PH_WG);
    end

endmodule

// File: tb/tb_sa_phase_scheduler.sv
// Directed bench for sa_phase_scheduler: cycle-exact timing, layer/phase order, stalls, abort, reset.
module tb_sa_phase_scheduler;

    logic        clk = 1'b0;
    logic        fsm_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  cfg_layers = 4'd0;
    logic [5:0]  cfg_tiles = 6'd0;
    logic [15:0] cfg_stride_mask = 16'h0000;
    logic        buf_ready = 1'b1;
    logic        busy, done, in_en, pe_clr, drain_en, stride;
    logic        buf_input_select, buf_output_select;
    logic [1:0]  phase, inpref_mode;
    logic [3:0]  layer_idx;
    logic [5:0]  tile_idx;
    logic [21:0] all_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    sa_phase_scheduler dut (
        .clk(clk), .fsm_rst_n(fsm_rst_n), .start(start), .abort(abort),
        .cfg_layers(cfg_layers), .cfg_tiles(cfg_tiles), .cfg_stride_mask(cfg_stride_mask),
        .buf_ready(buf_ready), .busy(busy), .done(done), .phase(phase),
        .layer_idx(layer_idx), .tile_idx(tile_idx), .in_en(in_en), .pe_clr(pe_clr),
        .drain_en(drain_en), .stride(stride), .inpref_mode(inpref_mode),
        .buf_input_select(buf_input_select), .buf_output_select(buf_output_select)
    );

    assign all_out = {busy, done, phase, layer_idx, tile_idx, in_en, pe_clr, drain_en,
                      stride, inpref_mode, buf_input_select, buf_output_select};

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start for one edge; afterwards cyc=1 is the cycle following the start edge.
    task automatic do_start(input logic [3:0] l, input logic [5:0] t, input logic [15:0] m);
        cfg_layers = l;
        cfg_tiles = t;
        cfg_stride_mask = m;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset;
        fsm_rst_n = 1'b0;
        step();
        step();
        checks++;
        if (all_out !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        fsm_rst_n = 1'b1;
        step();
        checks++;
        if (all_out !== 22'd0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0", all_out);
        end
    endtask

    // L=1,T=1: 14-cycle tiles starting at cycle 2, done at 44.
    task automatic test_basic;
        logic [10:0] obs, exp_v;
        buf_ready = 1'b1;
        do_start(4'd1, 6'd1, 16'h0000);
        for (int c = 1; c <= 46; c++) begin
            int k, o;
            logic e_in, e_dr, e_clr;
            logic [1:0] e_ph, e_inp;
            e_in = 1'b0; e_dr = 1'b0; e_clr = 1'b0; e_ph = 2'b00; e_inp = 2'b00;
            if (c >= 2 && c < 44) begin
                k = (c - 2) / 14;
                o = (c - 2) % 14;
                e_in = (o < 8);
                e_dr = (o >= 8) && (o < 12);
                e_clr = (o == 12);
                e_ph = (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b11);
                e_inp = 2'b01;
            end else if (c == 1) begin
                e_ph = 2'b01;
                e_inp = 2'b01;
            end
            exp_v = {(c <= 44), (c == 44), e_ph, e_in, e_dr, e_clr,
                     (e_ph == 2'b01), (e_ph == 2'b11), e_inp};
            obs = {busy, done, phase, in_en, drain_en, pe_clr,
                   buf_input_select, buf_output_select, inpref_mode};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL basic_cycle%0d got=%b exp=%b", c, obs, exp_v);
            end
            step();
        end
    endtask

    // L=3,T=2,mask=010: order of (phase,layer,tile) at each FEED entry plus stride/inpref.
    task automatic test_order;
        int ph[9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
        int ly[9] = '{0, 1, 2, 2, 1, 0, 2, 1, 0};
        int n = 0;
        int done_cyc = -1;
        logic prev_in = 1'b0;
        logic [14:0] obs, exp_v;
        buf_ready = 1'b1;
        do_start(4'd3, 6'd2, 16'h0002);
        while (cyc < 400 && done_cyc < 0) begin
            if (in_en && !prev_in) begin
                if (n < 18) begin
                    int j = n / 2;
                    int t = n % 2;
                    exp_v = {2'(ph[j]), 4'(ly[j]), 6'(t), (ly[j] == 1), (t != 0), (ly[j] != 1)};
                    obs = {phase, layer_idx, tile_idx, stride, inpref_mode};
                    checks++;
                    if (obs !== exp_v) begin
                        failures++;
                        $display("FAIL order_tile%0d got=%b exp=%b", n, obs, exp_v);
                    end
                end
                n++;
            end
            if (done) done_cyc = cyc;
            prev_in = in_en;
            step();
        end
        checks++;
        if (n !== 18 || done_cyc !== 254) begin
            failures++;
            $display("FAIL order_count tiles=%0d done_cycle=%0d exp tiles=18 done_cycle=254", n, done_cyc);
        end
        step();
    endtask

    // 5-cycle buf_ready stall in the first DRAIN: done slips from 44 to 49.
    task automatic test_stall;
        int pulses = 0;
        int done_cyc = -1;
        do_start(4'd1, 6'd1, 16'h0000);
        for (int c = 1; c <= 52; c++) begin
            logic e_dr;
            buf_ready = !(c >= 11 && c <= 15);
            #1;
            e_dr = ((c >= 10 && c <= 18) && buf_ready) || (c >= 29 && c <= 32) || (c >= 43 && c <= 46);
            checks++;
            if (drain_en !== e_dr) begin
                failures++;
                $display("FAIL stall_drain_cycle%0d got=%b exp=%b", c, drain_en, e_dr);
            end
            if (drain_en) pulses++;
            if (done) done_cyc = c;
            step();
        end
        buf_ready = 1'b1;
        checks++;
        if (pulses !== 12 || done_cyc !== 49) begin
            failures++;
            $display("FAIL stall_totals pulses=%0d done_cycle=%0d exp pulses=12 done_cycle=49", pulses, done_cyc);
        end
    endtask

    // T=0 and L=0 finish immediately without touching the array.
    task automatic test_zero;
        int strobes = 0;
        do_start(4'd1, 6'd0, 16'h0000);
        checks++;
        if ({busy, done, phase} !== 4'b1100) begin
            failures++;
            $display("FAIL zero_tiles_done got=%b exp=1100", {busy, done, phase});
        end
        for (int c = 1; c <= 6; c++) begin
            if (in_en || drain_en || pe_clr) strobes++;
            step();
        end
        checks++;
        if (strobes !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_tiles_quiet strobes=%0d busy=%b exp 0/0", strobes, busy);
        end
        do_start(4'd0, 6'd3, 16'h0000);
        checks++;
        if (done !== 1'b1 || in_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_layers_done done=%b in_en=%b exp 1/0", done, in_en);
        end
        step();
        step();
    endtask

    task automatic test_abort;
        int done_seen = 0;
        int done_cyc = -1;
        cfg_layers = 4'd1;
        cfg_tiles = 6'd1;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        checks++;
        if (all_out !== 22'd0) begin
            failures++;
            $display("FAIL start_abort_idle got=%h exp=0", all_out);
        end
        do_start(4'd2, 6'd1, 16'h0000);
        while (cyc < 32) step();
        checks++;
        if ({phase, layer_idx, in_en} !== {2'b10, 4'd1, 1'b1}) begin
            failures++;
            $display("FAIL abort_pre_bp_feed got=%b exp=1000011", {phase, layer_idx, in_en});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (all_out !== 22'd0) begin
            failures++;
            $display("FAIL abort_outputs got=%h exp=0", all_out);
        end
        for (int c = 0; c < 40; c++) begin
            if (done || busy) done_seen++;
            step();
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL abort_no_done active_cycles=%0d exp=0", done_seen);
        end
        do_start(4'd2, 6'd1, 16'h0000);
        step();
        checks++;
        if ({phase, layer_idx, tile_idx, in_en} !== {2'b01, 4'd0, 6'd0, 1'b1}) begin
            failures++;
            $display("FAIL abort_restart_fp0 got=%b exp=0100000000001", {phase, layer_idx, tile_idx, in_en});
        end
        while (cyc < 200 && done_cyc < 0) begin
            if (done) done_cyc = cyc;
            step();
        end
        checks++;
        if (done_cyc !== 86) begin
            failures++;
            $display("FAIL abort_restart_done got=%0d exp=86", done_cyc);
        end
    endtask

    // Reset asserted mid-DRAIN clears outputs before the next clock edge.
    task automatic test_async_reset;
        do_start(4'd1, 6'd1, 16'h0000);
        while (cyc < 11) step();
        checks++;
        if (drain_en !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_drain got=%b exp=1", drain_en);
        end
        #2;
        fsm_rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 22'd0) begin
            failures++;
            $display("FAIL areset_async_outputs got=%h exp=0", all_out);
        end
        step();
        fsm_rst_n = 1'b1;
        step();
        step();
        checks++;
        if (all_out !== 22'd0) begin
            failures++;
            $display("FAIL areset_idle got=%h exp=0", all_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_stall();
        test_zero();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
